// File: rtl/riscv_pkg.sv
// Shared RV32I core constants: next-PC select codes, the bubble encoding
// and the fetch FSM state encoding.
package riscv_pkg;

   localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
   localparam logic [1:0] PCSRC_BRANCH = 2'b01;
   localparam logic [1:0] PCSRC_JALR   = 2'b10;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef logic [1:0] fetchState_t;
   localparam fetchState_t S_REQ  = 2'd0;
   localparam fetchState_t S_WAIT = 2'd1;
   localparam fetchState_t S_HOLD = 2'd2;

endpackage

// File: rtl/fetch_stage_buf.sv
// fetch_buf: one-entry holding register for an instruction returned by
// instruction memory while it waits for handoff into IF/ID.
module fetch_buf
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        load,
   input  logic [31:0] instrIn,
   output logic        valid,
   output logic [31:0] instr
);

   logic        valid_r;
   logic [31:0] instr_r;

   // Clear wins over load so a redirect can never leave a stale word behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= 1'b0;
         instr_r <= 32'h0000_0000;
      end else if (clear) begin
         valid_r <= 1'b0;
      end else if (load) begin
         valid_r <= 1'b1;
         instr_r <= instrIn;
      end
   end

   assign valid = valid_r;
   assign instr = instr_r;

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register for the RV32I pipeline.
// Optional build macro FETCH_PERF_EN adds saturating bubble/redirect counters.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            stallF,
   input  logic            stallD,
   input  logic            flushD,
   input  logic [1:0]      pcsrcE,
   input  logic [XLEN-1:0] pctargetE,
   input  logic [XLEN-1:0] aluresultE,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instrD,
   output logic [XLEN-1:0] pcD,
   output logic [XLEN-1:0] pcplus4D,
   output logic            validD,
   output logic            fetch_busy
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_bubbles,
   output logic [31:0]     perf_redirects
`endif
);

   logic [XLEN-1:0] pcF_r, pcPlus4F_s, target_s;
   fetchState_t     state_r, stateNext_s;
   logic            drop_r, dropNext_s, armed_r;
   logic            redirect_s, handoff_s, bufLoad_s, bufClear_s, bufValid_s;
   logic [31:0]     bufInstr_s;
   logic [31:0]     instrD_r;
   logic [XLEN-1:0] pcD_r, pcplus4D_r;
   logic            validD_r;

   assign pcPlus4F_s = pcF_r + XLEN'(32'd4);

   // Next-PC select; the reserved code behaves exactly like PC+4.
   always_comb begin
      redirect_s = 1'b0;
      target_s   = pcPlus4F_s;
      case (pcsrcE)
         PCSRC_BRANCH: begin
            redirect_s = 1'b1;
            target_s   = pctargetE;
         end
         PCSRC_JALR: begin
            redirect_s = 1'b1;
            target_s   = aluresultE & {{(XLEN-1){1'b1}}, 1'b0};
         end
         PCSRC_PLUS4: begin
            redirect_s = 1'b0;
            target_s   = pcPlus4F_s;
         end
         default: begin
            redirect_s = 1'b0;
            target_s   = pcPlus4F_s;
         end
      endcase
   end

   // armed_r keeps req low while reset is held and for the first cycle after it.
   assign imem_req   = armed_r && (state_r == S_REQ) && !redirect_s;
   assign imem_addr  = pcF_r;
   assign handoff_s  = (state_r == S_HOLD) && !stallF && !stallD && !redirect_s;
   assign bufLoad_s  = (state_r == S_WAIT) && imem_rvalid && !drop_r && !redirect_s;
   assign bufClear_s = redirect_s || handoff_s;
   assign fetch_busy = !bufValid_s;

   fetch_buf u_buf (
      .clk     (clk),
      .rst     (rst),
      .clear   (bufClear_s),
      .load    (bufLoad_s),
      .instrIn (imem_rdata),
      .valid   (bufValid_s),
      .instr   (bufInstr_s)
   );

   // Fetch sequencing: one request outstanding; a response owed to a
   // redirected-away address is swallowed via drop.
   always_comb begin
      stateNext_s = state_r;
      dropNext_s  = drop_r;
      case (state_r)
         S_REQ: begin
            if (armed_r && imem_gnt) begin
               stateNext_s = S_WAIT;
               dropNext_s  = redirect_s;
            end else begin
               stateNext_s = S_REQ;
               dropNext_s  = 1'b0;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               dropNext_s = 1'b0;
               if (drop_r || redirect_s) begin
                  stateNext_s = S_REQ;
               end else begin
                  stateNext_s = S_HOLD;
               end
            end else begin
               dropNext_s  = drop_r || redirect_s;
               stateNext_s = S_WAIT;
            end
         end
         S_HOLD: begin
            dropNext_s = 1'b0;
            if (redirect_s || handoff_s) begin
               stateNext_s = S_REQ;
            end else begin
               stateNext_s = S_HOLD;
            end
         end
         default: begin
            stateNext_s = S_REQ;
            dropNext_s  = 1'b0;
         end
      endcase
   end

   // Control state and PCF; a redirect outranks stallF.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_REQ;
         drop_r  <= 1'b0;
         armed_r <= 1'b0;
         pcF_r   <= RESET_PC;
      end else begin
         state_r <= stateNext_s;
         drop_r  <= dropNext_s;
         armed_r <= 1'b1;
         if (redirect_s) begin
            pcF_r <= target_s;
         end else if (handoff_s) begin
            pcF_r <= pcPlus4F_s;
         end
      end
   end

   // IF/ID register: flush beats stall beats handoff; anything else is a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instrD_r   <= NOP_INSTR;
         pcD_r      <= {XLEN{1'b0}};
         pcplus4D_r <= {XLEN{1'b0}};
         validD_r   <= 1'b0;
      end else if (flushD) begin
         instrD_r   <= NOP_INSTR;
         pcD_r      <= {XLEN{1'b0}};
         pcplus4D_r <= {XLEN{1'b0}};
         validD_r   <= 1'b0;
      end else if (stallD) begin
         instrD_r   <= instrD_r;
         pcD_r      <= pcD_r;
         pcplus4D_r <= pcplus4D_r;
         validD_r   <= validD_r;
      end else if (handoff_s) begin
         instrD_r   <= bufInstr_s;
         pcD_r      <= pcF_r;
         pcplus4D_r <= pcPlus4F_s;
         validD_r   <= 1'b1;
      end else begin
         instrD_r   <= NOP_INSTR;
         pcD_r      <= {XLEN{1'b0}};
         pcplus4D_r <= {XLEN{1'b0}};
         validD_r   <= 1'b0;
      end
   end

   assign instrD   = instrD_r;
   assign pcD      = pcD_r;
   assign pcplus4D = pcplus4D_r;
   assign validD   = validD_r;

`ifdef FETCH_PERF_EN
   logic [31:0] perfBubbles_r, perfRedirects_r;
   logic        bubbleIn_s;

   assign bubbleIn_s = flushD || (!stallD && !handoff_s);

   // Saturating event counters; a stall hold is not a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perfBubbles_r   <= 32'h0000_0000;
         perfRedirects_r <= 32'h0000_0000;
      end else begin
         if (bubbleIn_s && (perfBubbles_r != 32'hFFFF_FFFF)) begin
            perfBubbles_r <= perfBubbles_r + 32'd1;
         end
         if (redirect_s && (perfRedirects_r != 32'hFFFF_FFFF)) begin
            perfRedirects_r <= perfRedirects_r + 32'd1;
         end
      end
   end

   assign perf_bubbles   = perfBubbles_r;
   assign perf_redirects = perfRedirects_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run against a program-order model of the delivered instruction stream.
`timescale 1ns/1ps
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallF, stallD, flushD;
   logic [1:0]  pcsrcE;
   logic [31:0] pctargetE, aluresultE;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] instrD, pcD, pcplus4D;
   logic        validD, fetch_busy;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_bubbles, perf_redirects;
`endif

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
      .pcsrcE(pcsrcE), .pctargetE(pctargetE), .aluresultE(aluresultE),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D), .validD(validD),
      .fetch_busy(fetch_busy)
`ifdef FETCH_PERF_EN
      , .perf_bubbles(perf_bubbles), .perf_redirects(perf_redirects)
`endif
   );

   int nCmp = 0;
   int nFail = 0;

   // Memory model: one outstanding request, fixed or random response latency.
   logic        pendValid;
   logic [31:0] pendAddr;
   int          pendWait;
   int          memLat;
   int          gntPct;
   logic        reqSeen, gntGiven, rvalidGiven;
   logic [31:0] addrSeen;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a << 16) ^ a ^ 32'hC0DE_0000;
   endfunction

   task automatic idleInputs();
      stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; pcsrcE = 2'b00;
   endtask

   // One clock: drive memory, settle, grant, clock edge, then sample at +1.
   task automatic step();
      rvalidGiven = pendValid && (pendWait == 0);
      imem_rvalid = rvalidGiven;
      imem_rdata  = rvalidGiven ? memWord(pendAddr) : $urandom();
      #1;
      reqSeen  = imem_req;
      addrSeen = imem_addr;
      gntGiven = imem_req && ($urandom_range(99) < gntPct);
      imem_gnt = gntGiven;
      @(posedge clk);
      if (rvalidGiven) pendValid = 1'b0;
      else if (pendValid) pendWait--;
      if (gntGiven) begin
         pendValid = 1'b1;
         pendAddr  = addrSeen;
         pendWait  = (memLat < 1) ? int'($urandom_range(2)) : memLat - 1;
      end
      #1;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
   endtask

   // Runs idle cycles until a valid instruction enters IF/ID (bounded).
   task automatic waitDeliver(output logic got, output logic [31:0] pc, output logic [31:0] instr,
                              output logic [31:0] p4, output logic [31:0] firstAddr, output int n);
      logic haveAddr;
      haveAddr = 1'b0; got = 1'b0; pc = 32'h0; instr = 32'h0; p4 = 32'h0;
      firstAddr = 32'hDEAD_BEEF; n = 0;
      idleInputs();
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         n++;
         if (gntGiven && !haveAddr) begin firstAddr = addrSeen; haveAddr = 1'b1; end
         if (validD === 1'b1) begin got = 1'b1; pc = pcD; instr = instrD; p4 = pcplus4D; end
      end
   endtask

   task automatic test_reset();
      nCmp++; if (imem_req !== 1'b0) begin nFail++; $display("FAIL reset_req: got %b want 0", imem_req); end
      nCmp++; if (imem_addr !== 32'h0) begin nFail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
      nCmp++; if (instrD !== NOP) begin nFail++; $display("FAIL reset_instrD: got %h want %h", instrD, NOP); end
      nCmp++; if ({pcD, pcplus4D} !== 64'h0) begin nFail++; $display("FAIL reset_pcD: got %h/%h want 0/0", pcD, pcplus4D); end
      nCmp++; if (validD !== 1'b0) begin nFail++; $display("FAIL reset_validD: got %b want 0", validD); end
      nCmp++; if (fetch_busy !== 1'b1) begin nFail++; $display("FAIL reset_busy: got %b want 1", fetch_busy); end
   endtask

   task automatic test_sequential();
      logic got; logic [31:0] pc, ins, p4, fa; int n;
      for (int k = 0; k < 2; k++) begin
         waitDeliver(got, pc, ins, p4, fa, n);
         nCmp++; if (!got || pc !== 32'(4 * k)) begin nFail++; $display("FAIL seq_pc%0d: got %h (got=%b) want %h", k, pc, got, 4 * k); end
         nCmp++; if (fa !== 32'(4 * k)) begin nFail++; $display("FAIL seq_addr%0d: got %h want %h", k, fa, 4 * k); end
         nCmp++; if (ins !== memWord(32'(4 * k)) || p4 !== 32'(4 * k + 4)) begin nFail++; $display("FAIL seq_data%0d: got %h/%h", k, ins, p4); end
         if (k == 1) begin
            nCmp++; if (n !== 3) begin nFail++; $display("FAIL seq_period: got %0d cycles want 3", n); end
         end
      end
   endtask

   task automatic test_stall();
      stallD = 1'b1;
      step();
      nCmp++; if (!(reqSeen && addrSeen === 32'h8)) begin nFail++; $display("FAIL stall_req8: got req=%b addr=%h", reqSeen, addrSeen); end
      step();
      nCmp++; if (fetch_busy !== 1'b0) begin nFail++; $display("FAIL stall_busy: got %b want 0", fetch_busy); end
      stallF = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         nCmp++; if (pcD !== 32'h4 || instrD !== memWord(32'h4) || validD !== 1'b1) begin
            nFail++; $display("FAIL stall_hold%0d: got pc=%h instr=%h v=%b", k, pcD, instrD, validD); end
         nCmp++; if (reqSeen !== 1'b0 || imem_addr !== 32'h8) begin
            nFail++; $display("FAIL stall_pcf%0d: got req=%b addr=%h want 0/8", k, reqSeen, imem_addr); end
      end
      idleInputs();
      step();
      nCmp++; if (pcD !== 32'h8 || instrD !== memWord(32'h8) || validD !== 1'b1 || pcplus4D !== 32'hC) begin
         nFail++; $display("FAIL stall_resume: got pc=%h instr=%h v=%b", pcD, instrD, validD); end
   endtask

   task automatic test_redirect_flush();
      logic got; logic [31:0] pc, ins, p4, fa; int n;
      step();
      nCmp++; if (addrSeen !== 32'hC || !gntGiven) begin nFail++; $display("FAIL rdf_req: got %h want c", addrSeen); end
      pcsrcE = 2'b01; pctargetE = 32'h100; flushD = 1'b1;
      step();
      nCmp++; if (instrD !== NOP || validD !== 1'b0) begin nFail++; $display("FAIL rdf_bubble: got %h v=%b", instrD, validD); end
      idleInputs();
      #1;
      nCmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin nFail++; $display("FAIL rdf_addr: got req=%b addr=%h want 1/100", imem_req, imem_addr); end
      waitDeliver(got, pc, ins, p4, fa, n);
      nCmp++; if (!got || pc !== 32'h100 || ins !== memWord(32'h100)) begin nFail++; $display("FAIL rdf_deliver: got %h/%h want 100", pc, ins); end
   endtask

   task automatic test_jalr();
      logic got; logic [31:0] pc, ins, p4, fa; int n;
      pcsrcE = 2'b10; aluresultE = 32'h203; flushD = 1'b1;
      step();
      nCmp++; if (reqSeen !== 1'b0) begin nFail++; $display("FAIL jalr_reqlow: got %b want 0", reqSeen); end
      waitDeliver(got, pc, ins, p4, fa, n);
      nCmp++; if (fa !== 32'h202) begin nFail++; $display("FAIL jalr_addr: got %h want 202", fa); end
      nCmp++; if (!got || pc !== 32'h202 || p4 !== 32'h206) begin nFail++; $display("FAIL jalr_deliver: got %h/%h", pc, p4); end
   endtask

   task automatic test_drop();
      logic got; logic [31:0] pc, ins, p4, fa; int n;
      memLat = 3;
      step();
      pcsrcE = 2'b01; pctargetE = 32'h40; flushD = 1'b1;
      step();
      idleInputs();
      #1;
      nCmp++; if (imem_addr !== 32'h40 || imem_req !== 1'b0) begin nFail++; $display("FAIL drop_wait: got addr=%h req=%b", imem_addr, imem_req); end
      waitDeliver(got, pc, ins, p4, fa, n);
      nCmp++; if (fa !== 32'h40) begin nFail++; $display("FAIL drop_addr: got %h want 40", fa); end
      nCmp++; if (!got || pc !== 32'h40 || ins !== memWord(32'h40)) begin nFail++; $display("FAIL drop_deliver: got %h/%h want 40/%h", pc, ins, memWord(32'h40)); end
   endtask

   task automatic test_reset_midflight();
      logic got; logic [31:0] pc, ins, p4, fa; int n;
      stallD = 1'b1; pcsrcE = 2'b01; pctargetE = 32'h20;
      step();
      pcsrcE = 2'b00;
      step();
      nCmp++; if (addrSeen !== 32'h20 || validD !== 1'b1) begin nFail++; $display("FAIL rstm_setup: got addr=%h v=%b", addrSeen, validD); end
      #2; rst = 1'b1; #1;
      test_reset();
      @(posedge clk); #1;
      rst = 1'b0; idleInputs();
      pendValid = 1'b1; pendWait = 0; pendAddr = 32'h20; memLat = 1;
      waitDeliver(got, pc, ins, p4, fa, n);
      nCmp++; if (fa !== 32'h0) begin nFail++; $display("FAIL rstm_addr: got %h want 0", fa); end
      nCmp++; if (!got || pc !== 32'h0 || ins !== memWord(32'h0)) begin nFail++; $display("FAIL rstm_deliver: got %h/%h", pc, ins); end
   endtask

   task automatic test_wrap();
      logic got; logic [31:0] pc, ins, p4, fa; int n;
      pcsrcE = 2'b01; pctargetE = 32'hFFFF_FFFC; flushD = 1'b1;
      step();
      waitDeliver(got, pc, ins, p4, fa, n);
      nCmp++; if (!got || pc !== 32'hFFFF_FFFC || p4 !== 32'h0) begin nFail++; $display("FAIL wrap_p4: got %h/%h want fffffffc/0", pc, p4); end
      waitDeliver(got, pc, ins, p4, fa, n);
      nCmp++; if (!got || pc !== 32'h0 || fa !== 32'h0) begin nFail++; $display("FAIL wrap_next: got pc=%h addr=%h want 0", pc, fa); end
   endtask

   task automatic test_random();
      logic        redir, prevWait;
      logic [31:0] tgt, expPc, pInstr, pPc, pP4, prevAddr;
      logic        pValid;
      int          nDel;
      expPc = 32'h4; nDel = 0; prevWait = 1'b0; prevAddr = 32'h0;
      pInstr = instrD; pPc = pcD; pP4 = pcplus4D; pValid = validD;
      gntPct = 75; memLat = 0;
      for (int i = 0; i < 800; i++) begin
         stallD = ($urandom_range(99) < 15);
         stallF = ($urandom_range(99) < 12);
         redir = ($urandom_range(99) < 5);
         tgt = 32'h0;
         if (redir) begin
            pctargetE = {22'h0, 8'($urandom_range(255)), 2'b00};
            aluresultE = 32'($urandom_range(1023));
            pcsrcE = $urandom_range(1) ? 2'b10 : 2'b01;
            tgt = (pcsrcE == 2'b10) ? (aluresultE & 32'hFFFF_FFFE) : pctargetE;
            flushD = 1'b1;
         end else begin
            pcsrcE = ($urandom_range(99) < 4) ? 2'b11 : 2'b00;
            flushD = 1'b0;
         end
         step();
         if (prevWait && !redir) begin
            nCmp++; if (!reqSeen || addrSeen !== prevAddr) begin nFail++; $display("FAIL rnd_reqstable@%0d: got req=%b addr=%h want 1/%h", i, reqSeen, addrSeen, prevAddr); end
         end
         prevWait = reqSeen && !gntGiven;
         prevAddr = addrSeen;
         if (flushD) begin
            nCmp++; if (validD !== 1'b0 || instrD !== NOP) begin nFail++; $display("FAIL rnd_flush@%0d: got %h v=%b", i, instrD, validD); end
         end else if (stallD) begin
            nCmp++; if ({instrD, pcD, pcplus4D, validD} !== {pInstr, pPc, pP4, pValid}) begin
               nFail++; $display("FAIL rnd_hold@%0d: got %h/%h v=%b want %h/%h v=%b", i, instrD, pcD, validD, pInstr, pPc, pValid); end
         end else if (validD === 1'b1) begin
            nCmp++; if (pcD !== expPc || instrD !== memWord(expPc) || pcplus4D !== expPc + 32'd4) begin
               nFail++; $display("FAIL rnd_deliver@%0d: got %h/%h want %h/%h", i, pcD, instrD, expPc, memWord(expPc)); end
            expPc = expPc + 32'd4;
            nDel++;
         end else begin
            nCmp++; if (instrD !== NOP) begin nFail++; $display("FAIL rnd_bubble@%0d: got %h want %h", i, instrD, NOP); end
         end
         if (redir) expPc = tgt;
         pInstr = instrD; pPc = pcD; pP4 = pcplus4D; pValid = validD;
      end
      nCmp++; if (nDel < 60) begin nFail++; $display("FAIL rnd_progress: got %0d deliveries want >= 60", nDel); end
      idleInputs();
   endtask

   initial begin
      rst = 1'b1; idleInputs();
      pctargetE = 32'h0; aluresultE = 32'h0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      pendValid = 1'b0; pendAddr = 32'h0; pendWait = 0; memLat = 1; gntPct = 100;
      #2;
      test_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      test_sequential();
      test_stall();
      test_redirect_flush();
      test_jalr();
      test_drop();
      test_reset_midflight();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
